// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit and its branch target buffer.
// Covers the counter encoding, the BTB entry layout and the next-PC source select.
package pc_pkg;

    // Widest address the BTB entry fields can hold; instantiate with XLEN <= PC_XLEN.
    localparam int PC_XLEN = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_t;

    typedef struct packed {
        logic                valid;
        logic [PC_XLEN-1:0]  tag;
        logic [PC_XLEN-1:0]  target;
        bp_cnt_t             cnt;
    } btb_entry_t;

    typedef enum logic [2:0] {
        TRAP,
        MRET,
        EXRED,
        HOLD,
        PRED,
        SEQ
    } npc_sel_t;

    function automatic bp_cnt_t satInc(input bp_cnt_t c);
        case (c)
            SNT:     return WNT;
            WNT:     return WT;
            default: return ST;
        endcase
    endfunction

    function automatic bp_cnt_t satDec(input bp_cnt_t c);
        case (c)
            ST:      return WT;
            WT:      return WNT;
            default: return SNT;
        endcase
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit counters.
// The lookup port is combinational; the update port writes on the clock edge.
module pc_btb
    import pc_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [XLEN-1:0]  i_lkPc,
    output logic             o_predTaken,
    output logic [XLEN-1:0]  o_predTarget,
    input  logic             i_updValid,
    input  logic [XLEN-1:0]  i_updPc,
    input  logic [XLEN-1:0]  i_updTarget,
    input  logic             i_updTaken
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    btb_entry_t r_btb [BTB_ENTRIES];

    logic [IDX-1:0]  w_lkIdx;
    logic [TAGW-1:0] w_lkTag;
    btb_entry_t      w_lkEntry;
    logic            w_lkHit;
    logic [IDX-1:0]  w_updIdx;
    logic [TAGW-1:0] w_updTag;
    btb_entry_t      w_updEntry;
    logic            w_updHit;
    logic            w_unusedLowBits;

    // Instructions are word aligned, so the two low PC bits never select anything.
    assign w_unusedLowBits = ^{i_lkPc[1:0], i_updPc[1:0]};

    assign w_lkIdx   = i_lkPc[IDX+1:2];
    assign w_lkTag   = i_lkPc[XLEN-1:IDX+2];
    assign w_lkEntry = r_btb[w_lkIdx];
    assign w_lkHit   = w_lkEntry.valid &&
                       (w_lkEntry.tag == {{(PC_XLEN-TAGW){1'b0}}, w_lkTag});

    assign o_predTaken  = w_lkHit & w_lkEntry.cnt[1];
    assign o_predTarget = w_lkHit ? w_lkEntry.target[XLEN-1:0] : '0;

    assign w_updIdx   = i_updPc[IDX+1:2];
    assign w_updTag   = i_updPc[XLEN-1:IDX+2];
    assign w_updEntry = r_btb[w_updIdx];
    assign w_updHit   = w_updEntry.valid &&
                        (w_updEntry.tag == {{(PC_XLEN-TAGW){1'b0}}, w_updTag});

    // Only valid bits are cleared on reset; stale tags/targets are masked by them.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb[i].valid <= 1'b0;
            end
        end else if (i_updValid) begin
            if (w_updHit) begin
                r_btb[w_updIdx].cnt <= i_updTaken ? satInc(w_updEntry.cnt)
                                                  : satDec(w_updEntry.cnt);
                if (i_updTaken) begin
                    r_btb[w_updIdx].target <= PC_XLEN'(i_updTarget);
                end
            end else if (i_updTaken) begin
                r_btb[w_updIdx].valid  <= 1'b1;
                r_btb[w_updIdx].tag    <= {{(PC_XLEN-TAGW){1'b0}}, w_updTag};
                r_btb[w_updIdx].target <= PC_XLEN'(i_updTarget);
                r_btb[w_updIdx].cnt    <= WT;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch address and picks the next PC from
// trap/return/EX redirects, stall hold, BTB prediction or the sequential address.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_vec,
    input  logic             mret_valid,
    input  logic [XLEN-1:0]  mret_pc,
    input  logic             ex_redirect_valid,
    input  logic [XLEN-1:0]  ex_redirect_pc,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_taken,
    output logic [XLEN-1:0]  addr,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_nextPc;
    logic            w_predTaken;
    logic [XLEN-1:0] w_predTarget;
    npc_sel_t        w_sel;

    pc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_lkPc       (r_pc),
        .o_predTaken  (w_predTaken),
        .o_predTarget (w_predTarget),
        .i_updValid   (upd_valid),
        .i_updPc      (upd_pc),
        .i_updTarget  (upd_target),
        .i_updTaken   (upd_taken)
    );

    // Redirects outrank halt; halt outranks the BTB prediction.
    always_comb begin
        w_sel = SEQ;
        if (trap_valid)             w_sel = TRAP;
        else if (mret_valid)        w_sel = MRET;
        else if (ex_redirect_valid) w_sel = EXRED;
        else if (halt)              w_sel = HOLD;
        else if (w_predTaken)       w_sel = PRED;
    end

    always_comb begin
        w_nextPc = r_pc + XLEN'(4);
        case (w_sel)
            TRAP:    w_nextPc = trap_vec & ALIGN_MASK;
            MRET:    w_nextPc = mret_pc & ALIGN_MASK;
            EXRED:   w_nextPc = ex_redirect_pc & ALIGN_MASK;
            HOLD:    w_nextPc = r_pc;
            PRED:    w_nextPc = w_predTarget & ALIGN_MASK;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= w_nextPc;
        end
    end

    assign addr        = r_pc;
    assign pred_taken  = w_predTaken;
    assign pred_target = w_predTarget;

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: reset, sequencing, redirect priority, halt,
// BTB allocation/counter walk, aliasing, address wrap and reset during update.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        halt;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        mret_valid;
    logic [31:0] mret_pc;
    logic        ex_redirect_valid;
    logic [31:0] ex_redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] addr;
    logic        pred_taken;
    logic [31:0] pred_target;

    int nChecks = 0;
    int nPass   = 0;

    pc_unit #(
        .XLEN        (32),
        .RESET_VEC   (32'h0000_1000),
        .BTB_ENTRIES (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .halt              (halt),
        .trap_valid        (trap_valid),
        .trap_vec          (trap_vec),
        .mret_valid        (mret_valid),
        .mret_pc           (mret_pc),
        .ex_redirect_valid (ex_redirect_valid),
        .ex_redirect_pc    (ex_redirect_pc),
        .upd_valid         (upd_valid),
        .upd_pc            (upd_pc),
        .upd_target        (upd_target),
        .upd_taken         (upd_taken),
        .addr              (addr),
        .pred_taken        (pred_taken),
        .pred_target       (pred_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed === expected) nPass++;
        else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic checkPc(input string tag, input logic [31:0] expected);
        checkOutput(tag, addr, expected);
    endtask

    task automatic checkPred(input string tag, input logic taken, input logic [31:0] target);
        checkOutput({tag, ".taken"}, {31'b0, pred_taken}, {31'b0, taken});
        checkOutput({tag, ".target"}, pred_target, target);
    endtask

    // One clock edge with the staged inputs; pulse inputs drop afterwards.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        trap_valid        = 1'b0;
        mret_valid        = 1'b0;
        ex_redirect_valid = 1'b0;
        upd_valid         = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = pc;
        applyStimulus();
    endtask

    task automatic update(input logic [31:0] pc, input logic [31:0] target, input logic taken);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = target;
        upd_taken  = taken;
        applyStimulus();
    endtask

    initial begin
        reset = 1'b0; halt = 1'b0;
        trap_valid = 1'b0; trap_vec = '0;
        mret_valid = 1'b0; mret_pc = '0;
        ex_redirect_valid = 1'b0; ex_redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;

        applyStimulus();
        applyStimulus();
        checkPc("rst_addr", 32'h1000);
        checkPred("rst_pred", 1'b0, 32'h0);

        reset = 1'b1;
        applyStimulus(); checkPc("seq1", 32'h1004);
        applyStimulus(); checkPc("seq2", 32'h1008);

        redirect(32'h10); checkPc("exred", 32'h10);
        halt = 1'b1;
        applyStimulus(); checkPc("halt1", 32'h10);
        applyStimulus(); checkPc("halt2", 32'h10);
        trap_valid = 1'b1; trap_vec = 32'h203;
        applyStimulus(); checkPc("trap_over_halt", 32'h200);
        halt = 1'b0;

        trap_valid = 1'b1; trap_vec = 32'h300;
        mret_valid = 1'b1; mret_pc = 32'h400;
        ex_redirect_valid = 1'b1; ex_redirect_pc = 32'h500;
        applyStimulus(); checkPc("prio_trap", 32'h300);
        mret_valid = 1'b1; mret_pc = 32'h400;
        applyStimulus(); checkPc("mret", 32'h400);
        mret_valid = 1'b1; mret_pc = 32'h404;
        ex_redirect_valid = 1'b1; ex_redirect_pc = 32'h600;
        applyStimulus(); checkPc("prio_mret", 32'h404);
        redirect(32'h501); checkPc("exred_align", 32'h500);

        // BTB allocation and counter walk while the PC is held.
        halt = 1'b1;
        update(32'h20, 32'h80, 1'b1);
        checkPc("upd_under_halt", 32'h500);
        checkPred("miss_other", 1'b0, 32'h0);
        redirect(32'h20); checkPc("redir20", 32'h20);
        checkPred("alloc", 1'b1, 32'h80);
        halt = 1'b0;
        applyStimulus(); checkPc("pred_follow", 32'h80);
        checkPred("pred_at80", 1'b0, 32'h0);

        halt = 1'b1;
        redirect(32'h20);
        update(32'h20, 32'h84, 1'b1); checkPred("cnt_st", 1'b1, 32'h84);
        update(32'h20, 32'h99, 1'b0); checkPred("cnt_wt", 1'b1, 32'h84);
        update(32'h20, 32'h99, 1'b0); checkPred("cnt_wnt", 1'b0, 32'h84);
        update(32'h20, 32'h99, 1'b0); checkPred("cnt_snt", 1'b0, 32'h84);
        update(32'h20, 32'h99, 1'b0); checkPred("cnt_snt_sat", 1'b0, 32'h84);
        update(32'h20, 32'h88, 1'b1); checkPred("cnt_wnt_up", 1'b0, 32'h88);
        update(32'h20, 32'h88, 1'b1); checkPred("cnt_wt_up", 1'b1, 32'h88);
        halt = 1'b0;
        applyStimulus(); checkPc("pred_follow2", 32'h88);

        halt = 1'b1;
        redirect(32'h20);
        update(32'h20, 32'h0, 1'b0);
        update(32'h20, 32'h0, 1'b0);
        halt = 1'b0;
        applyStimulus(); checkPc("snt_seq", 32'h24);

        // 0x20, 0x60 and 0xA0 all share index 8 with different tags.
        halt = 1'b1;
        update(32'h60, 32'h100, 1'b1);
        redirect(32'h20); checkPred("alias_20_miss", 1'b0, 32'h0);
        upd_valid = 1'b1; upd_pc = 32'hA0; upd_target = 32'h300; upd_taken = 1'b0;
        redirect(32'h60); checkPc("redir60", 32'h60);
        checkPred("alias_60_hit", 1'b1, 32'h100);
        halt = 1'b0;
        applyStimulus(); checkPc("alias_follow", 32'h100);

        halt = 1'b1;
        redirect(32'hFFFF_FFFC);
        checkPred("wrap_nopred", 1'b0, 32'h0);
        halt = 1'b0;
        applyStimulus(); checkPc("wrap", 32'h0);
        applyStimulus(); checkPc("wrap_next", 32'h4);

        // Reset wins over trap and discards a coincident update.
        reset = 1'b0;
        trap_valid = 1'b1; trap_vec = 32'h300;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_target = 32'h200; upd_taken = 1'b1;
        applyStimulus(); checkPc("rst_mid", 32'h1000);
        reset = 1'b1;
        halt  = 1'b1;
        redirect(32'h60); checkPred("rst_clear60", 1'b0, 32'h0);
        redirect(32'h40); checkPred("rst_discard40", 1'b0, 32'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
